// File: rtl/vid_pkg.sv
// vid_pkg: shared state enum, 1080p timing defaults and passthrough beat type for vid_timing_det
package vid_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} vtd_state_e;
  localparam int H_WIDTH_1080P  = 1920;
  localparam int H_TOTAL_1080P  = 2200;
  localparam int V_HEIGHT_1080P = 1080;
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] data;
  } vid_beat_t;
endpackage

// File: rtl/vid_edge_det.sv
// vid_edge_det: registered rise/fall detector (rise = d & ~q, fall = ~d & q)
// Ports: clk_i, rst_i (sync, active-high), d_i level in, rise_o/fall_o combinational edge strobes.
module vid_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic q;
  always_ff @(posedge clk_i) q <= rst_i ? 1'b0 : d_i;
  assign rise_o = d_i & ~q;
  assign fall_o = ~d_i & q;
endmodule

// File: rtl/vid_timing_det.sv
// vid_timing_det: video timing checker, 1-cycle passthrough and pixel x/y tagger
// Ports: clk_i/rst_i (sync, active-high); hs_i/vs_i/de_i/data_i in; hs_o/vs_o/de_o/data_o delayed 1 cycle;
// x_o/y_o/sof_o coordinates aligned with de_o; h_width_o/h_total_o/v_height_o measurements;
// locked_o, mismatch_o status; err_cnt_o bad-frame count (built only with VID_TIMING_DET_ERRCNT_EN).
module vid_timing_det
  import vid_pkg::*;
#(
  parameter int H_WIDTH     = H_WIDTH_1080P,
  parameter int H_TOTAL     = H_TOTAL_1080P,
  parameter int V_HEIGHT    = V_HEIGHT_1080P,
  parameter int LOCK_FRAMES = 2,
  parameter int XW          = 12,
  parameter int YW          = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hs_i,
  input  logic          vs_i,
  input  logic          de_i,
  input  logic [23:0]   data_i,
  output logic          hs_o,
  output logic          vs_o,
  output logic          de_o,
  output logic [23:0]   data_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          sof_o,
  output logic [XW-1:0] h_width_o,
  output logic [XW-1:0] h_total_o,
  output logic [YW-1:0] v_height_o,
  output logic          locked_o,
  output logic          mismatch_o,
  output logic [15:0]   err_cnt_o
);
  localparam logic [XW-1:0] X_MAX = '1;
  localparam logic [YW-1:0] Y_MAX = '1;
  vtd_state_e state, state_nxt;
  vid_beat_t beat;
  logic vs_rise, vs_fall_unused, de_rise, de_fall;
  logic [XW-1:0] x_cnt, p_cnt, x_idx;
  logic [YW-1:0] y_cnt, y_idx, y_lines;
  logic [3:0] good, good_nxt;
  logic first_q, bad_q, p_chk, bad_now, frame_bad, evaluate;

  vid_edge_det u_vs_edge (.clk_i(clk_i), .rst_i(rst_i), .d_i(vs_i), .rise_o(vs_rise), .fall_o(vs_fall_unused));
  vid_edge_det u_de_edge (.clk_i(clk_i), .rst_i(rst_i), .d_i(de_i), .rise_o(de_rise), .fall_o(de_fall));

  // y_lines already includes a line ending this cycle so a coincident vs rise counts it.
  // The first de rise of a frame has no predecessor, so its period is neither latched nor checked.
  always_comb begin
    x_idx     = de_rise ? '0 : x_cnt;
    y_idx     = vs_rise ? '0 : y_cnt;
    y_lines   = (de_fall && y_cnt != Y_MAX) ? y_cnt + 1'b1 : y_cnt;
    p_chk     = de_rise & ~first_q & ~vs_rise;
    bad_now   = bad_q | (de_i & (x_idx == X_MAX)) | (de_fall & (x_cnt != XW'(H_WIDTH)))
              | (p_chk & (p_cnt != XW'(H_TOTAL)));
    frame_bad = bad_now | de_i | (y_lines != YW'(V_HEIGHT));
    evaluate  = vs_rise & (state != IDLE);
    state_nxt = !vs_rise ? state
              : (state == IDLE || frame_bad) ? MEASURE
              : (state == LOCKED || good + 1'b1 == 4'(LOCK_FRAMES)) ? LOCKED : MEASURE;
    good_nxt  = !vs_rise ? good : (state == MEASURE && !frame_bad) ? good + 1'b1 : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat       <= '0;
      x_o        <= '0;
      y_o        <= '0;
      sof_o      <= 1'b0;
      h_width_o  <= '0;
      h_total_o  <= '0;
      v_height_o <= '0;
      locked_o   <= 1'b0;
      mismatch_o <= 1'b0;
      state      <= IDLE;
      good       <= '0;
      x_cnt      <= '0;
      p_cnt      <= '0;
      y_cnt      <= '0;
      first_q    <= 1'b1;
      bad_q      <= 1'b0;
    end else begin
      beat       <= {hs_i, vs_i, de_i, data_i};
      x_cnt      <= de_i ? ((x_idx == X_MAX) ? X_MAX : x_idx + 1'b1) : x_cnt;
      p_cnt      <= de_rise ? XW'(1) : (p_cnt == X_MAX) ? X_MAX : p_cnt + 1'b1;
      y_cnt      <= vs_rise ? '0 : y_lines;
      first_q    <= de_rise ? 1'b0 : (vs_rise | first_q);
      bad_q      <= ~vs_rise & bad_now;
      x_o        <= de_i ? x_idx : '0;
      y_o        <= y_idx;
      sof_o      <= de_i & (x_idx == '0) & (y_idx == '0);
      h_width_o  <= de_fall ? x_cnt : h_width_o;
      h_total_o  <= p_chk ? p_cnt : h_total_o;
      v_height_o <= evaluate ? y_lines : v_height_o;
      mismatch_o <= evaluate & frame_bad;
      state      <= state_nxt;
      good       <= good_nxt;
      locked_o   <= state_nxt == LOCKED;
    end
  end

`ifdef VID_TIMING_DET_ERRCNT_EN
  logic [15:0] err_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt <= '0;
    else if (evaluate && frame_bad && err_cnt != 16'hffff) err_cnt <= err_cnt + 1'b1;
  end
  assign err_cnt_o = err_cnt;
`else
  assign err_cnt_o = '0;
`endif

  assign hs_o   = beat.hs;
  assign vs_o   = beat.vs;
  assign de_o   = beat.de;
  assign data_o = beat.data;
endmodule

// File: tb/tb_vid_timing_det.sv
// tb_vid_timing_det: self-checking bench for vid_timing_det with a per-beat scoreboard
module tb_vid_timing_det;
  localparam int HW = 16, HT = 24, VH = 4, LF = 2, XW = 12, YW = 11;
`ifdef VID_TIMING_DET_ERRCNT_EN
  localparam logic [15:0] EXP_ERR3 = 16'd3;
`else
  localparam logic [15:0] EXP_ERR3 = 16'd0;
`endif
  logic clk = 1'b0, rst = 1'b1, hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [23:0] data = '0;
  logic hs_o, vs_o, de_o, sof_o, locked_o, mismatch_o;
  logic [23:0] data_o;
  logic [XW-1:0] x_o, h_width_o, h_total_o;
  logic [YW-1:0] y_o, v_height_o;
  logic [15:0] err_cnt_o;

  typedef struct {
    logic hs; logic vs; logic de; logic [23:0] data;
    logic [XW-1:0] x; logic [YW-1:0] y; logic sof; logic cx; logic cy;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, mis_seen = 0, sof_seen = 0;
  logic lk_pre, lk_at_vs, mis_at_vs;
  logic [YW-1:0] vh_at_vs;
  logic [XW-1:0] last_w, w_short;

  always #5 clk = ~clk;

  vid_timing_det #(.H_WIDTH(HW), .H_TOTAL(HT), .V_HEIGHT(VH), .LOCK_FRAMES(LF), .XW(XW), .YW(YW)) dut (
    .clk_i(clk), .rst_i(rst), .hs_i(hs), .vs_i(vs), .de_i(de), .data_i(data),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .data_o(data_o), .x_o(x_o), .y_o(y_o), .sof_o(sof_o),
    .h_width_o(h_width_o), .h_total_o(h_total_o), .v_height_o(v_height_o),
    .locked_o(locked_o), .mismatch_o(mismatch_o), .err_cnt_o(err_cnt_o)
  );

  task automatic cyc(input logic r, input logic h, input logic v, input logic d, input int xe, input int ye, input logic chk);
    exp_t e;
    logic [23:0] dv;
    dv = 24'($urandom);
    e.hs = ~r & h; e.vs = ~r & v; e.de = ~r & d; e.data = r ? 24'h0 : dv;
    e.x = (r | ~d) ? '0 : XW'(xe);
    e.y = r ? '0 : YW'(ye);
    e.sof = ~r & d & (xe == 0) & (ye == 0);
    e.cx = r | chk; e.cy = r | (chk & d);
    q.push_back(e);
    rst = r; hs = h; vs = v; de = d; data = dv;
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (hs_o !== e.hs || vs_o !== e.vs || de_o !== e.de || data_o !== e.data ||
        (e.cx && (x_o !== e.x || sof_o !== e.sof)) || (e.cy && y_o !== e.y)) begin
      errors++;
      $display("FAIL beat @%0t: got hs=%b vs=%b de=%b data=%h x=%0d y=%0d sof=%b, exp hs=%b vs=%b de=%b data=%h x=%0d y=%0d sof=%b",
               $time, hs_o, vs_o, de_o, data_o, x_o, y_o, sof_o, e.hs, e.vs, e.de, e.data, e.x, e.y, e.sof);
    end
    if (mismatch_o === 1'b1) mis_seen++;
    if (sof_o === 1'b1) sof_seen++;
  endtask

  task automatic line(input int npix, input int y, input logic chk);
    for (int p = 0; p < npix; p++) cyc(1'b0, 1'b0, 1'b0, 1'b1, p, y, chk);
    for (int b = 0; b < HT - npix; b++) begin
      cyc(1'b0, b < 2, 1'b0, 1'b0, 0, y, chk);
      if (b == 0) last_w = h_width_o;
    end
  endtask

  task automatic frame(input int nlines, input int short_idx, input logic de_vs);
    lk_pre = locked_o;
    cyc(1'b0, 1'b0, 1'b1, de_vs, 0, 0, ~de_vs);
    lk_at_vs = locked_o; mis_at_vs = mismatch_o; vh_at_vs = v_height_o;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, ~de_vs);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, ~de_vs);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, ~de_vs);
    for (int l = 0; l < nlines; l++) begin
      line((l == short_idx) ? HW - 1 : HW, l, ~de_vs);
      if (l == short_idx) w_short = last_w;
    end
  endtask

  task automatic test_reset;
    logic [2*XW+YW+17:0] st;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 5, 5, 1'b1);
    st = {h_width_o, h_total_o, v_height_o, locked_o, mismatch_o, err_cnt_o};
    checks++;
    if (st !== '0) begin errors++; $display("FAIL reset_status: got %h, exp 0", st); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_nominal;
    int m0;
    m0 = mis_seen;
    for (int i = 0; i < 4; i++) begin
      frame(VH, -1, 1'b0);
      checks++;
      if (lk_at_vs !== (i >= 2)) begin errors++; $display("FAIL nominal_lock vs%0d: got %b, exp %b", i + 1, lk_at_vs, i >= 2); end
      if (i == 2) begin
        checks++;
        if (lk_pre !== 1'b0) begin errors++; $display("FAIL nominal_prelock: got %b, exp 0", lk_pre); end
      end
    end
    checks++;
    if (mis_seen - m0 != 0) begin errors++; $display("FAIL nominal_mismatch: got %0d pulses, exp 0", mis_seen - m0); end
    checks++;
    if (h_width_o !== XW'(HW) || h_total_o !== XW'(HT) || v_height_o !== YW'(VH)) begin
      errors++; $display("FAIL nominal_meas: got w=%0d t=%0d h=%0d, exp w=%0d t=%0d h=%0d", h_width_o, h_total_o, v_height_o, HW, HT, VH);
    end
  endtask

  task automatic test_coords;
    int s0;
    s0 = sof_seen;
    frame(VH, -1, 1'b0);
    checks++;
    if (sof_seen - s0 != 1) begin errors++; $display("FAIL coords_sof: got %0d pulses, exp 1", sof_seen - s0); end
    checks++;
    if (locked_o !== 1'b1) begin errors++; $display("FAIL coords_lock: got %b, exp 1", locked_o); end
  endtask

  task automatic test_short_line;
    int m0;
    frame(VH, 1, 1'b0);
    checks++;
    if (w_short !== XW'(HW - 1)) begin errors++; $display("FAIL short_width: got %0d, exp %0d", w_short, HW - 1); end
    m0 = mis_seen;
    frame(VH, -1, 1'b0);
    checks++;
    if (mis_at_vs !== 1'b1 || lk_at_vs !== 1'b0) begin errors++; $display("FAIL short_eval: got mis=%b lock=%b, exp mis=1 lock=0", mis_at_vs, lk_at_vs); end
    frame(VH, -1, 1'b0);
    checks++;
    if (lk_at_vs !== 1'b0) begin errors++; $display("FAIL short_relock1: got %b, exp 0", lk_at_vs); end
    frame(VH, -1, 1'b0);
    checks++;
    if (lk_at_vs !== 1'b1) begin errors++; $display("FAIL short_relock2: got %b, exp 1", lk_at_vs); end
    checks++;
    if (mis_seen - m0 != 1) begin errors++; $display("FAIL short_pulses: got %0d, exp 1", mis_seen - m0); end
  endtask

  task automatic test_bad_frames;
    frame(VH + 1, -1, 1'b0);
    frame(VH, -1, 1'b0);
    checks++;
    if (mis_at_vs !== 1'b1 || vh_at_vs !== YW'(VH + 1)) begin errors++; $display("FAIL tall_frame: got mis=%b h=%0d, exp mis=1 h=%0d", mis_at_vs, vh_at_vs, VH + 1); end
    frame(VH, -1, 1'b1);
    checks++;
    if (mis_at_vs !== 1'b1 || vh_at_vs !== YW'(VH)) begin errors++; $display("FAIL de_at_vs: got mis=%b h=%0d, exp mis=1 h=%0d", mis_at_vs, vh_at_vs, VH); end
    frame(VH, -1, 1'b0);
    checks++;
    if (mis_at_vs !== 1'b1) begin errors++; $display("FAIL polluted_frame: got mis=%b, exp 1", mis_at_vs); end
    frame(VH, -1, 1'b0);
    checks++;
    if (mis_at_vs !== 1'b0 || lk_at_vs !== 1'b0) begin errors++; $display("FAIL recover1: got mis=%b lock=%b, exp 0 0", mis_at_vs, lk_at_vs); end
    frame(VH, -1, 1'b0);
    checks++;
    if (lk_at_vs !== 1'b1) begin errors++; $display("FAIL recover2: got lock=%b, exp 1", lk_at_vs); end
  endtask

  task automatic test_reset_mid;
    logic [2*XW+YW+17:0] st;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int p = 0; p < 5; p++) cyc(1'b0, 1'b0, 1'b0, 1'b1, p, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5, 0, 1'b1);
    st = {h_width_o, h_total_o, v_height_o, locked_o, mismatch_o, err_cnt_o};
    checks++;
    if (st !== '0) begin errors++; $display("FAIL midreset_status: got %h, exp 0", st); end
    for (int b = 0; b < 20; b++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      frame(VH, -1, 1'b0);
      checks++;
      if (lk_at_vs !== (i == 2)) begin errors++; $display("FAIL midreset_lock vs%0d: got %b, exp %b", i + 1, lk_at_vs, i == 2); end
    end
  endtask

  task automatic test_err_cnt;
    int m0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    m0 = mis_seen;
    for (int i = 0; i < 3; i++) frame(VH + 1, -1, 1'b0);
    frame(VH, -1, 1'b0);
    checks++;
    if (mis_seen - m0 != 3) begin errors++; $display("FAIL err_pulses: got %0d, exp 3", mis_seen - m0); end
    checks++;
    if (err_cnt_o !== EXP_ERR3) begin errors++; $display("FAIL err_cnt: got %0d, exp %0d", err_cnt_o, EXP_ERR3); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_nominal;
    test_coords;
    test_short_line;
    test_bad_frames;
    test_reset_mid;
    test_err_cnt;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vid_timing_det.md
# vid_timing_det

- Single-clock video timing checker and pixel-coordinate generator.
- Sits between the HDMI receiver output and the processing stages, and is clocked by the recovered pixel clock.
- Passes hs/vs/de/data through with a fixed one-cycle latency and tags every active pixel with its x/y position.
- Measures line width, line period and frame height, and asserts `locked_o` once consecutive frames match the configured 1080p geometry.

## Interface
Parameters:
- `H_WIDTH`, 1920, expected active pixels per line.
- `H_TOTAL`, 2200, expected clocks from one de rising edge to the next.
- `V_HEIGHT`, 1080, expected active lines per frame.
- `LOCK_FRAMES`, 2, consecutive good frames required for lock (1..15).
- `XW`, 12, width of horizontal counters.
- `YW`, 11, width of vertical counters.

Ports (clock and reset first):
- `clk_i` in 1: pixel clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `hs_i` / `vs_i` / `de_i` in 1 each: input sync and data-enable signals; active-high.
- `data_i` in 24: input pixel.
- `hs_o` / `vs_o` / `de_o` in/out: out 1 each; `hs_i`/`vs_i`/`de_i` delayed by 1 cycle.
- `data_o` out 24: `data_i` delayed by 1 cycle.
- `x_o` out XW: pixel column, valid while `de_o`=1.
- `y_o` out YW: active line index.
- `sof_o` out 1: pulse on first active pixel of a frame.
- `h_width_o` out XW: width of the last completed line.
- `h_total_o` out XW: last measured line period.
- `v_height_o` out YW: line count of the last completed frame.
- `locked_o` out 1: timing locked.
- `mismatch_o` out 1: one-cycle pulse when a bad frame is evaluated.
- `err_cnt_o` out 16: bad-frame count (see Configuration).

## Operation
Edge detection:
- The block keeps registered copies of vs and de.
- A rising edge is `x_i & ~x_q`; a falling edge is `~x_i & x_q`.

Coordinate counters:
- x resets to 0 on the de rising edge and increments each de cycle. It saturates at 2^XW-1; saturation marks the frame bad.
- y resets to 0 on the vs rising edge and increments on each de falling edge. It saturates at 2^YW-1.

Measurements:
- The width counter is latched into `h_width_o` on the de falling edge. If the width ≠ H_WIDTH, the frame is marked bad.
- The period counter runs from one de rising edge to the next. It is latched into `h_total_o` on every de rising edge except the first of the frame. If the period ≠ H_TOTAL, the frame is marked bad.

Frame evaluation on the vs rising edge:
- `v_height_o` ← line count.
- The frame is bad if the line count ≠ V_HEIGHT, the bad flag is set, or de=1 on that cycle.
- The bad flag is cleared afterwards.

State machine (states in `vid_pkg`):
- IDLE: wait for the first vs rise, then go to MEASURE with good count = 0. No evaluation happens in IDLE; the partial frame is discarded.
- MEASURE:
  - Good frame: good count +1. When the count reaches LOCK_FRAMES, go to LOCKED.
  - Bad frame: good count ← 0 and `mismatch_o` pulses.
- LOCKED:
  - Good frame: stay in LOCKED.
  - Bad frame: go to MEASURE with good count 0 and pulse `mismatch_o`.
- `locked_o` = (state == LOCKED).

Reset:
- Every output is 0.
- The state machine returns to IDLE.
- Counters and the bad flag are cleared.
- A reset mid-frame aborts that frame; lock is reacquired only after the next vs rise plus LOCK_FRAMES good frames.

## Timing
Passthrough and coordinates:
- Passthrough latency is exactly 1 cycle.
- `x_o`/`y_o`/`sof_o` are aligned with `de_o`/`data_o`.
- `x_o` = 0 whenever `de_o` = 0.
- `y_o` holds its value through horizontal blanking.
- `sof_o` is high only while `de_o`=1, `x_o`=0 and `y_o`=0.

Status updates:
- `h_width_o` and `h_total_o` update the cycle after their respective de edge is sampled.
- `v_height_o`, `locked_o`, `mismatch_o` and `err_cnt_o` update the cycle after vs_i is first sampled high.

Simultaneous events:
- If vs rises in the same cycle as a de falling edge, that line is counted before evaluation.
- If vs rises together with a de rising edge, the frame is bad.

## Configuration
- `VID_TIMING_DET_ERRCNT_EN` defined: `err_cnt_o` is a saturating 16-bit counter, incremented on every `mismatch_o` pulse. It is cleared only by reset.
- `VID_TIMING_DET_ERRCNT_EN` undefined: `err_cnt_o` is tied to 0 and no counter logic is built.

## Structure
- Package `vid_pkg` holds:
  - state enum `vtd_state_e` (IDLE, MEASURE, LOCKED);
  - the 1080p default timing constants;
  - the passthrough struct `vid_beat_t` (hs, vs, de, data[23:0]).
- Sub-module `vid_edge_det`: registered rise/fall detector, used for both vs and de.

## Test plan
Bench uses H_WIDTH=16, H_TOTAL=24, V_HEIGHT=4, LOCK_FRAMES=2.
- Nominal timing, 4 frames → `locked_o` rises 1 cycle after the 3rd vs rise; `mismatch_o` never pulses; `h_width_o`=16, `h_total_o`=24, `v_height_o`=4.
- Coordinate check → first active pixel gives `sof_o`=1, x=0, y=0; last active pixel gives x=15, y=3; `data_o` equals `data_i` one cycle earlier.
- While locked, one line with 15 pixels → `h_width_o`=15; at the next vs rise, `mismatch_o` pulses once and `locked_o` falls; lock returns after 2 further good frames.
- Frame with 5 lines → `v_height_o`=5, frame bad; vs rising with de=1 → frame bad.
- `rst_i` asserted mid-line for 1 cycle → all outputs 0 next cycle; no lock until the 3rd vs rise after reset.
- With `VID_TIMING_DET_ERRCNT_EN`, 3 bad frames → `err_cnt_o`=3; without the macro → `err_cnt_o` stays 0.
